// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN MAC array.
// FSM encoding, index widths and the requantise function.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT,
        FIN
    } macStateT;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idxW(input int v);
        return (v > 1) ? clog2(v) : 1;
    endfunction

    // Arithmetic shift, optional ReLU, then clamp to a signed ow-bit range.
    function automatic logic signed [63:0] requant(
        input logic signed [63:0] acc,
        input int                 sh,
        input int                 ow,
        input logic               relu
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = acc >>> sh;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (relu && v < 0) v = '0;
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_mac_array_if.sv
// Activation input and OFM output streams of the MAC array.
interface conv_mac_array_if #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int OW = 8,
    parameter int AW = 8
) ();

    logic                 act_valid;
    logic                 act_ready;
    logic signed [DW-1:0] act_data;

    logic                 ofm_valid;
    logic                 ofm_ready;
    logic [N*OW-1:0]      ofm_data;
    logic [AW-1:0]        ofm_addr;

    modport master (
        output act_valid,
        output act_data,
        input  act_ready,
        input  ofm_valid,
        input  ofm_data,
        input  ofm_addr,
        output ofm_ready
    );

    modport slave (
        input  act_valid,
        input  act_data,
        output act_ready,
        output ofm_valid,
        output ofm_data,
        output ofm_addr,
        input  ofm_ready
    );

endinterface

// File: rtl/conv_mac_lane.sv
// One filter lane: K local weights, signed MAC and requantised output.
module conv_mac_lane
    import cnn_pkg::*;
#(
    parameter int DW    = 8,
    parameter int K     = 9,
    parameter int OW    = 8,
    parameter int SHIFT = 4,
    localparam int KW   = idxW(K)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrEn,
    input  logic [KW-1:0]        wrAddr,
    input  logic signed [DW-1:0] wrData,
    input  logic [KW-1:0]        tap,
    input  logic                 accEn,
    input  logic                 accClr,
    input  logic signed [DW-1:0] act,
    input  logic                 relu,
    output logic signed [OW-1:0] q
);

    localparam int ACC_W = 2 * DW + clog2(K);

    logic signed [DW-1:0]    wt [K];
    logic signed [DW-1:0]    wCur;
    logic signed [ACC_W-1:0] wExt;
    logic signed [ACC_W-1:0] aExt;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc;

    // Weights survive reset so a run can be repeated after an abort.
    always_ff @(posedge clk) begin
        if (wrEn && 32'(wrAddr) < K) begin
            wt[wrAddr] <= wrData;
        end
    end

    assign wCur = wt[tap];
    assign wExt = {{(ACC_W-DW){wCur[DW-1]}}, wCur};
    assign aExt = {{(ACC_W-DW){act[DW-1]}}, act};
    assign prod = wExt * aExt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (accClr) begin
            acc <= '0;
        end else if (accEn) begin
            acc <= acc + prod;
        end
    end

    assign q = OW'(requant(64'(acc), SHIFT, OW, relu));

endmodule

// File: rtl/conv_mac_array.sv
// N-lane convolution MAC array: shared activation stream, per-lane weights,
// one requantised OFM word per output pixel.
module conv_mac_array
    import cnn_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int K     = 9,
    parameter int OW    = 8,
    parameter int SHIFT = 4,
    parameter int AW    = 8,
    localparam int LW   = idxW(N),
    localparam int KW   = idxW(K)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 relu_en,
    input  logic [AW-1:0]        num_out,
    output logic                 ready,
    output logic                 done,
    input  logic                 wt_we,
    input  logic [LW-1:0]        wt_lane,
    input  logic [KW-1:0]        wt_addr,
    input  logic signed [DW-1:0] wt_data,
    conv_mac_array_if.slave      bus
);

    macStateT      state;
    macStateT      nxt;
    logic [KW-1:0] tap;
    logic [AW-1:0] addr;
    logic [AW-1:0] numOut;
    logic          reluReg;
    logic          accEn;
    logic          accClr;
    logic          wrEn;
    logic          lastTap;
    logic          lastOut;
    logic          ofmFire;

    assign lastTap = (tap == KW'(K - 1));
    assign lastOut = (addr == numOut - AW'(1));
    assign ofmFire = (state == OUT) && bus.ofm_ready;
    assign wrEn    = wt_we && (state == IDLE);

    always_comb begin
        nxt    = state;
        accEn  = 1'b0;
        accClr = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accClr = 1'b1;
                    nxt    = (num_out == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (bus.act_valid) begin
                    accEn = 1'b1;
                    if (lastTap) nxt = OUT;
                end
            end
            OUT: begin
                if (bus.ofm_ready) begin
                    accClr = 1'b1;
                    nxt    = lastOut ? FIN : RUN;
                end
            end
            FIN: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap     <= '0;
            addr    <= '0;
            numOut  <= '0;
            reluReg <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                tap     <= '0;
                numOut  <= num_out;
                reluReg <= relu_en;
            end
            if (state == RUN && bus.act_valid && !lastTap) begin
                tap <= tap + KW'(1);
            end
            if (ofmFire) begin
                tap  <= '0;
                addr <= addr + AW'(1);
            end
            if (state == FIN) begin
                addr <= '0;
            end
        end
    end

    assign ready         = (state == IDLE);
    assign done          = (state == FIN);
    assign bus.act_ready = (state == RUN);
    assign bus.ofm_valid = (state == OUT);
    assign bus.ofm_addr  = addr;

    for (genvar i = 0; i < N; i++) begin : gLane
        logic signed [OW-1:0] laneQ;

        conv_mac_lane #(
            .DW    (DW),
            .K     (K),
            .OW    (OW),
            .SHIFT (SHIFT)
        ) uLane (
            .clk    (clk),
            .reset  (reset),
            .wrEn   (wrEn && (wt_lane == LW'(i))),
            .wrAddr (wt_addr),
            .wrData (wt_data),
            .tap    (tap),
            .accEn  (accEn),
            .accClr (accClr),
            .act    (bus.act_data),
            .relu   (reluReg),
            .q      (laneQ)
        );

        assign bus.ofm_data[i*OW +: OW] = laneQ;
    end

endmodule

// File: tb/tb_conv_mac_array.sv
// Scoreboard bench: two array instances (SHIFT 0 and SHIFT 4) on shared stimulus.
module tb_conv_mac_array;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int K  = 9;
    localparam int OW = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 start = 1'b0;
    logic                 reluEn = 1'b0;
    logic [AW-1:0]        numOut = '0;
    logic                 wtWe = 1'b0;
    logic [1:0]           wtLane = '0;
    logic [3:0]           wtAddr = '0;
    logic signed [DW-1:0] wtData = '0;
    logic                 actValid = 1'b0;
    logic signed [DW-1:0] actData = '0;
    logic                 ofmReady = 1'b0;
    logic                 ready0, done0, ready4, done4;

    conv_mac_array_if #(.N(N), .DW(DW), .OW(OW), .AW(AW)) if0 ();
    conv_mac_array_if #(.N(N), .DW(DW), .OW(OW), .AW(AW)) if4 ();

    assign if0.act_valid = actValid;
    assign if0.act_data  = actData;
    assign if0.ofm_ready = ofmReady;
    assign if4.act_valid = actValid;
    assign if4.act_data  = actData;
    assign if4.ofm_ready = ofmReady;

    conv_mac_array #(.N(N), .DW(DW), .K(K), .OW(OW), .SHIFT(0), .AW(AW)) dut0 (
        .clk(clk), .reset(rst_n), .start(start), .relu_en(reluEn),
        .num_out(numOut), .ready(ready0), .done(done0), .wt_we(wtWe),
        .wt_lane(wtLane), .wt_addr(wtAddr), .wt_data(wtData), .bus(if0)
    );

    conv_mac_array #(.N(N), .DW(DW), .K(K), .OW(OW), .SHIFT(4), .AW(AW)) dut4 (
        .clk(clk), .reset(rst_n), .start(start), .relu_en(reluEn),
        .num_out(numOut), .ready(ready4), .done(done4), .wt_we(wtWe),
        .wt_lane(wtLane), .wt_addr(wtAddr), .wt_data(wtData), .bus(if4)
    );

    typedef struct {
        logic [AW-1:0]   addr;
        logic [N*OW-1:0] d0;
        logic [N*OW-1:0] d4;
    } expT;

    expT sb[$];
    expT e;
    int  passCnt = 0;
    int  totalCnt = 0;
    int  doneCnt = 0;
    int  acts[K];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        totalCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Monitor: pops an expectation for every OFM handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done0) doneCnt++;
            if (if0.ofm_valid && ofmReady) begin
                if (sb.size() == 0) begin
                    check("ofm unexpected", {63'b0, if0.ofm_valid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("ofm_addr", 64'(if0.ofm_addr), 64'(e.addr));
                    check("ofm_data shift0", 64'(if0.ofm_data), 64'(e.d0));
                    check("ofm_valid shift4", {63'b0, if4.ofm_valid}, 64'd1);
                    check("ofm_data shift4", 64'(if4.ofm_data), 64'(e.d4));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrWt(input int lane, input int t, input int v);
        wtWe   = 1'b1;
        wtLane = lane[1:0];
        wtAddr = t[3:0];
        wtData = v[7:0];
        tick();
        wtWe = 1'b0;
    endtask

    task automatic setLane(input int lane, input int v);
        for (int t = 0; t < K; t++) wrWt(lane, t, v);
    endtask

    task automatic setActs(input int mode);
        for (int i = 0; i < K; i++) acts[i] = (mode == 0) ? i + 1 : mode;
    endtask

    task automatic startRun(input int n, input bit relu);
        numOut = n[AW-1:0];
        reluEn = relu;
        start  = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int a);
        int c;
        c = 0;
        actValid = 1'b1;
        actData  = a[7:0];
        while (!if0.act_ready && c < 40) begin
            tick();
            c++;
        end
        if (!if0.act_ready) check("act_ready timeout", {63'b0, if0.act_ready}, 64'd1);
        tick();
        actValid = 1'b0;
    endtask

    task automatic runOne(input bit relu, input bit same, input logic [31:0] e0, input logic [31:0] e4);
        sb.push_back('{addr: '0, d0: e0, d4: e4});
        if (same) begin
            wtWe   = 1'b1;
            wtLane = 2'd3;
            wtAddr = 4'd0;
            wtData = 8'sd10;
        end
        startRun(1, relu);
        wtWe = 1'b0;
        for (int i = 0; i < K; i++) feed(acts[i]);
        check("ofm_valid latency", {63'b0, if0.ofm_valid}, 64'd1);
        tick();
        check("done after handshake", {63'b0, done0}, 64'd1);
        tick();
        check("done one cycle", {63'b0, done0}, 64'd0);
        check("ready after run", {63'b0, ready0}, 64'd1);
    endtask

    logic [31:0] a0, a4;
    int doneBase;

    initial begin
        a0 = pack4(45, -45, 90, 0);
        a4 = pack4(2, -3, 5, 0);
        tick();
        tick();
        check("reset ready", {63'b0, ready0}, 64'd1);
        check("reset done", {63'b0, done0}, 64'd0);
        check("reset act_ready", {63'b0, if0.act_ready}, 64'd0);
        check("reset ofm_valid", {63'b0, if0.ofm_valid}, 64'd0);
        check("reset ofm_data", 64'(if0.ofm_data), 64'd0);
        check("reset ofm_addr", 64'(if0.ofm_addr), 64'd0);
        rst_n = 1'b1;
        tick();

        setLane(0, 1);
        setLane(1, -1);
        setLane(2, 2);
        setLane(3, 0);
        setActs(0);
        ofmReady = 1'b1;

        runOne(1'b0, 1'b0, a0, a4);
        runOne(1'b1, 1'b0, pack4(45, 0, 90, 0), pack4(2, 0, 5, 0));
        runOne(1'b0, 1'b1, pack4(45, -45, 90, 10), a4);
        wrWt(3, 0, 0);

        for (int l = 0; l < N; l++) setLane(l, 127);
        setActs(127);
        runOne(1'b0, 1'b0, pack4(127, 127, 127, 127), pack4(127, 127, 127, 127));
        setActs(-128);
        runOne(1'b0, 1'b0, pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128));

        setLane(0, 1);
        setLane(1, -1);
        setLane(2, 2);
        setLane(3, 0);
        setActs(0);

        // Three outputs, each held off by five cycles of backpressure.
        doneBase = doneCnt;
        for (int o = 0; o < 3; o++) sb.push_back('{addr: AW'(o), d0: a0, d4: a4});
        ofmReady = 1'b0;
        startRun(3, 1'b0);
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < K; i++) feed(acts[i]);
            for (int s = 0; s < 5; s++) begin
                check("stall ofm_valid", {63'b0, if0.ofm_valid}, 64'd1);
                check("stall act_ready", {63'b0, if0.act_ready}, 64'd0);
                check("stall ofm_data", 64'(if0.ofm_data), 64'(a0));
                check("stall ofm_addr", 64'(if0.ofm_addr), 64'(o));
                tick();
            end
            ofmReady = 1'b1;
            tick();
            ofmReady = 1'b0;
        end
        check("stall done", {63'b0, done0}, 64'd1);
        tick();
        tick();
        check("stall done count", 64'(doneCnt - doneBase), 64'd1);
        ofmReady = 1'b1;

        startRun(0, 1'b0);
        check("zero-out done", {63'b0, done0}, 64'd1);
        check("zero-out ofm_valid", {63'b0, if0.ofm_valid}, 64'd0);
        tick();
        check("zero-out ready", {63'b0, ready0}, 64'd1);

        // start and wt_we while running must be ignored.
        sb.push_back('{addr: '0, d0: a0, d4: a4});
        startRun(1, 1'b0);
        for (int i = 0; i < 3; i++) feed(acts[i]);
        startRun(5, 1'b0);
        wrWt(0, 0, 100);
        for (int i = 3; i < K; i++) feed(acts[i]);
        check("ignored ofm_valid", {63'b0, if0.ofm_valid}, 64'd1);
        tick();
        check("ignored done", {63'b0, done0}, 64'd1);
        tick();
        for (int s = 0; s < 3; s++) begin
            check("ignored no extra out", {63'b0, if0.ofm_valid}, 64'd0);
            tick();
        end
        runOne(1'b0, 1'b0, a0, a4);

        // Abort a run with reset, then repeat it.
        startRun(1, 1'b0);
        for (int i = 0; i < 4; i++) feed(acts[i]);
        rst_n = 1'b0;
        #1;
        check("abort ready", {63'b0, ready0}, 64'd1);
        check("abort act_ready", {63'b0, if0.act_ready}, 64'd0);
        check("abort ofm_data", 64'(if0.ofm_data), 64'd0);
        check("abort done", {63'b0, done0}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        runOne(1'b0, 1'b0, a0, a4);

        tick();
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/conv_mac_array.md
Name: conv_mac_array

Overview:
- Parametrised successor to the single-configuration CNN MAC top.
- N parallel filter lanes share one activation stream. Each lane computes a K-tap signed dot product against its own locally stored weights.
- Each result is requantised (shift, optional ReLU, saturate) and emitted as one OFM word per output pixel, over a valid/ready handshake with an OFM address.
- Sits between the window buffer (activation source) and the OFM memory.

Parameters:
- N, 4, number of filter lanes (1..16)
- DW, 8, signed activation/weight width
- K, 9, taps per output pixel (kernel size x channels), >=1
- OW, 8, signed output width per lane
- SHIFT, 4, arithmetic right shift applied to the accumulator before saturation
- AW, 8, OFM address / output-count width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a run when idle
- relu_en  in  1  sampled at start; clamps negative results to 0
- num_out  in  AW  output pixels per run, sampled at start
- ready  out  1  high when idle and a start is accepted
- done  out  1  one-cycle pulse at end of run
- wt_we  in  1  weight write strobe; honoured only when idle
- wt_lane  in  clog2(N)  target lane
- wt_addr  in  clog2(K)  tap index
- wt_data  in  DW  signed weight
- act_valid  in  1  activation valid
- act_ready  out  1  activation accepted when valid and ready are both high
- act_data  in  DW  signed activation, broadcast to all lanes
- ofm_valid  out  1  result valid
- ofm_ready  in  1  sink accepts the result
- ofm_data  out  N*OW  lane i occupies bits [i*OW +: OW]
- ofm_addr  out  AW  output index, 0..num_out-1

Behaviour:
- Reset values: ready=1, done=0, act_ready=0, ofm_valid=0, ofm_data=0, ofm_addr=0. FSM state is IDLE, tap and output counters are 0, accumulators are 0. Weight storage is not reset.
- Accumulator width: ACC_W = 2*DW + clog2(K). Overflow is impossible by construction.
- IDLE:
  - wt_we writes weight[wt_lane][wt_addr].
  - start captures num_out and relu_en and clears the accumulators.
  - If num_out==0, go to FIN; otherwise go to RUN.
- RUN:
  - act_ready=1.
  - Each accepted activation at tap t adds weight[i][t]*act_data to acc[i] for every lane, then t increments.
  - On acceptance of tap K-1, go to OUT. The next cycle has ofm_valid=1 (one-cycle latency from the last tap).
- OUT:
  - act_ready=0 and ofm_valid=1.
  - ofm_data lane i = sat_OW(relu(acc[i] >>> SHIFT)). The shift is arithmetic; relu is applied only if the captured relu_en=1.
  - Saturation clamps to [-2^(OW-1), 2^(OW-1)-1].
  - ofm_data and ofm_addr hold stable until ofm_valid and ofm_ready are both high.
  - On handshake: ofm_addr increments, accumulators and tap counter clear.
  - If ofm_addr was num_out-1, go to FIN; otherwise return to RUN.
- FIN: done=1 for one cycle; ofm_addr returns to 0; go to IDLE.
- ready is high only in IDLE.
- Boundary and conflict rules:
  - start outside IDLE: ignored.
  - wt_we outside IDLE: ignored (weights stable during a run).
  - start and wt_we in the same IDLE cycle: the write completes and the run starts; the new weight applies to this run.
  - act_valid outside RUN: not accepted.
  - ofm_ready held low: unlimited backpressure with no data loss; act_ready remains 0.
  - K==1: every accepted activation produces an output.
  - Asserting reset mid-run: immediate return to reset values, no done pulse. Weights are retained.

Decomposition:
- Shared package cnn_pkg:
  - clog2 function
  - FSM state encoding IDLE/RUN/OUT/FIN
  - sat/relu requantise function parametrised by ACC_W/OW
- Sub-module conv_mac_lane, instantiated N times via generate. It holds:
  - K x DW weight registers with write port
  - multiply-accumulate over ACC_W
  - requantise output
- The top holds the FSM, tap and output counters, and the handshake logic.

Test Plan:
- Weights lane0 all +1, lane1 all -1; K=9, SHIFT=0, relu_en=0, num_out=1; activations 1..9 -> ofm_data lane0=45, lane1=-45; ofm_addr=0; done one cycle after handshake.
- Same setup with relu_en=1 -> lane1=0, lane0=45.
- Saturation: all weights 127, activations 127, SHIFT=4, OW=8 -> every lane output 127. With activations -128 -> -128.
- num_out=3, ofm_ready held low 5 cycles at each output -> act_ready=0 while waiting; ofm_data stable; addresses 0,1,2 in order; a single done pulse.
- num_out=0 -> done one cycle after start, no ofm_valid. A start during RUN is ignored (output count unchanged). A wt_we during RUN does not alter the result.
- Assert reset after 4 taps, release, rerun with identical stimulus -> fresh correct result; no stale accumulation; weights intact.
